// File: rtl/param_regfile_if.sv
// Bus bundle for param_regfile: one byte-enabled write port and two
// independent read ports (A and B). clk/reset stay plain module ports.
interface param_regfile_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = WIDTH / 8;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [BW-1:0]    wr_be;

  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_valid_a;

  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid_b;

  // Requester side.
  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );
endinterface

// File: rtl/param_regfile.sv
// Parameterised register file: one byte-enabled write port, two registered
// read ports with write-first bypass, optional hardwired zero register at
// index DEPTH-1. WIDTH must be a multiple of 8 (>= 8); DEPTH is 2..256.
// The interface instance must be built with the same WIDTH and DEPTH.
module param_regfile #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           reset,
  param_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = WIDTH / 8;

  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] reg_next [DEPTH];
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;

  // Index DEPTH-1 is read-only zero when ZERO_REG is set.
  function automatic logic is_writable(input int idx);
    return !((ZERO_REG != 0) && (idx == DEPTH - 1));
  endfunction

  // Post-write view of every register: the old value merged with the enabled
  // bytes of the current write. Both the state update and the read bypass use
  // it, so write-first behaviour falls out for free. Addresses >= DEPTH match
  // no entry and are therefore ignored.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned, which would infer a latch.
      reg_next[i] = regs[i];
      if (bus.wr_en && (bus.wr_addr == AW'(i)) && is_writable(i)) begin
        for (int b = 0; b < BW; b++) begin
          if (bus.wr_be[b]) reg_next[i][8*b +: 8] = bus.wr_data[8*b +: 8];
        end
      end
      if (!is_writable(i)) reg_next[i] = '0;
    end
  end

  // Read-address muxes; an index with no matching entry reads as zero.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr_a == AW'(i)) rd_next_a = reg_next[i];
      if (bus.rd_addr_b == AW'(i)) rd_next_b = reg_next[i];
    end
  end

  // Register storage update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is normally left unreset so it can map onto RAM, but
      // here an asynchronous clear of every entry is a functional requirement,
      // so the array is built from resettable flops.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      for (int i = 0; i < DEPTH; i++) regs[i] <= reg_next[i];
    end
  end

  // Registered read ports: data only advances on a request, valid follows it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_data_a  <= '0;
      bus.rd_valid_a <= 1'b0;
      bus.rd_data_b  <= '0;
      bus.rd_valid_b <= 1'b0;
    end else begin
      bus.rd_valid_a <= bus.rd_en_a;
      bus.rd_valid_b <= bus.rd_en_b;
      if (bus.rd_en_a) bus.rd_data_a <= rd_next_a;
      if (bus.rd_en_b) bus.rd_data_b <= rd_next_b;
    end
  end
endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile. Four instances share one stimulus:
//   dut0: 64-bit x 32, zero register on
//   dut1: 64-bit x 32, zero register off
//   dut2: 32-bit x 16, zero register on (sees the low address/data/be bits)
//   dut3: 64-bit x 20, zero register off (indices 20..31 are out of range)
module tb_param_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_be;
  logic        ra_en, rb_en;
  logic [4:0]  ra_addr, rb_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  param_regfile_if #(.WIDTH(64), .DEPTH(32)) if0 ();
  param_regfile_if #(.WIDTH(64), .DEPTH(32)) if1 ();
  param_regfile_if #(.WIDTH(32), .DEPTH(16)) if2 ();
  param_regfile_if #(.WIDTH(64), .DEPTH(20)) if3 ();

  assign if0.wr_en = w_en;  assign if0.wr_addr = w_addr;  assign if0.wr_data = w_data;
  assign if0.wr_be = w_be;  assign if0.rd_en_a = ra_en;   assign if0.rd_addr_a = ra_addr;
  assign if0.rd_en_b = rb_en; assign if0.rd_addr_b = rb_addr;

  assign if1.wr_en = w_en;  assign if1.wr_addr = w_addr;  assign if1.wr_data = w_data;
  assign if1.wr_be = w_be;  assign if1.rd_en_a = ra_en;   assign if1.rd_addr_a = ra_addr;
  assign if1.rd_en_b = rb_en; assign if1.rd_addr_b = rb_addr;

  assign if2.wr_en = w_en;  assign if2.wr_addr = w_addr[3:0]; assign if2.wr_data = w_data[31:0];
  assign if2.wr_be = w_be[3:0]; assign if2.rd_en_a = ra_en; assign if2.rd_addr_a = ra_addr[3:0];
  assign if2.rd_en_b = rb_en; assign if2.rd_addr_b = rb_addr[3:0];

  assign if3.wr_en = w_en;  assign if3.wr_addr = w_addr;  assign if3.wr_data = w_data;
  assign if3.wr_be = w_be;  assign if3.rd_en_a = ra_en;   assign if3.rd_addr_a = ra_addr;
  assign if3.rd_en_b = rb_en; assign if3.rd_addr_b = rb_addr;

  param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  param_regfile #(.WIDTH(64), .DEPTH(32), .ZERO_REG(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  param_regfile #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
  param_regfile #(.WIDTH(64), .DEPTH(20), .ZERO_REG(0)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
  endtask

  initial begin
    reset = 1'b1;
    w_en = 0; w_addr = 0; w_data = 0; w_be = 0;
    ra_en = 1; ra_addr = 0; rb_en = 1; rb_addr = 0;  // reads during reset are ignored
    #3;
    check("rst_async_valid_a", 64'(if0.rd_valid_a), 64'd0);
    check("rst_async_data_a", if0.rd_data_a, 64'd0);
    step(); step();
    check("rst_hold_valid_a", 64'(if0.rd_valid_a), 64'd0);
    check("rst_hold_valid_b", 64'(if0.rd_valid_b), 64'd0);
    reset = 1'b0; ra_en = 0; rb_en = 0;

    // Full-width write then read on A one cycle later.
    write(5'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    step();
    check("pre_read_valid_a", 64'(if0.rd_valid_a), 64'd0);
    w_en = 0; ra_en = 1; ra_addr = 5'd5;
    step();
    check("full_rd_data", if0.rd_data_a, 64'hDEADBEEF_CAFEF00D);
    check("full_rd_valid", 64'(if0.rd_valid_a), 64'd1);
    check("full_rd_w32", 64'(if2.rd_data_a), 64'h00000000_CAFEF00D);
    check("full_rd_d20", if3.rd_data_a, 64'hDEADBEEF_CAFEF00D);

    // Hold: three idle cycles on A.
    ra_en = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_valid_a", 64'(if0.rd_valid_a), 64'd0);
      check("hold_data_a", if0.rd_data_a, 64'hDEADBEEF_CAFEF00D);
    end

    // Byte enables on reg 3.
    write(5'd3, 64'h11223344_55667788, 8'hFF);
    step();
    write(5'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    step();
    w_en = 0; ra_en = 1; ra_addr = 5'd3; rb_en = 1; rb_addr = 5'd3;
    step();
    check("be_low_a", if0.rd_data_a, 64'h11223344_FFFFFFFF);
    check("be_low_b", if0.rd_data_b, 64'h11223344_FFFFFFFF);

    // No-change writes: be all zero, then wr_en low.
    write(5'd3, 64'h0, 8'h00);
    step();
    check("be_zero_nochg", if0.rd_data_a, 64'h11223344_FFFFFFFF);
    w_en = 0; w_be = 8'hFF;
    step();
    check("wr_en_low_nochg", if0.rd_data_a, 64'h11223344_FFFFFFFF);

    // Bypass: both ports read reg 7 while it is written.
    write(5'd7, 64'h0000_0000_0000_A5A5, 8'h03);
    ra_addr = 5'd7; rb_addr = 5'd7;
    step();
    check("bypass_a", if0.rd_data_a, 64'h00000000_0000A5A5);
    check("bypass_b", if0.rd_data_b, 64'h00000000_0000A5A5);
    w_en = 0;
    step();
    check("bypass_committed", if0.rd_data_a, 64'h00000000_0000A5A5);

    // Bypass merge with a non-zero old value; B reads another index.
    write(5'd3, 64'hAA00_0000_0000_0000, 8'h80);
    ra_addr = 5'd3; rb_addr = 5'd5;
    step();
    check("bypass_merge_a", if0.rd_data_a, 64'hAA223344_FFFFFFFF);
    check("indep_b", if0.rd_data_b, 64'hDEADBEEF_CAFEF00D);

    // B idle while A reads: B valid drops, B data holds.
    w_en = 0; rb_en = 0; ra_addr = 5'd7;
    step();
    check("b_idle_valid", 64'(if0.rd_valid_b), 64'd0);
    check("b_idle_hold", if0.rd_data_b, 64'hDEADBEEF_CAFEF00D);
    check("a_busy_valid", 64'(if0.rd_valid_a), 64'd1);

    // Zero register and out-of-range index.
    write(5'd31, 64'h1234, 8'hFF);
    ra_en = 0;
    step();
    w_en = 0; ra_en = 1; ra_addr = 5'd31;
    step();
    check("zreg_on", if0.rd_data_a, 64'd0);
    check("zreg_on_valid", 64'(if0.rd_valid_a), 64'd1);
    check("zreg_off", if1.rd_data_a, 64'h1234);
    check("zreg_w32", 64'(if2.rd_data_a), 64'd0);
    check("oor_d20", if3.rd_data_a, 64'd0);
    check("oor_d20_valid", 64'(if3.rd_valid_a), 64'd1);
    write(5'd31, 64'h5678, 8'h03);
    step();
    check("zreg_on_bypass", if0.rd_data_a, 64'd0);
    check("zreg_off_bypass", if1.rd_data_a, 64'h5678);

    // Load regs 0..30, then pulse reset between edges.
    ra_en = 0;
    for (int i = 0; i <= 30; i++) begin
      write(5'(i), 64'h01234567_00000000 + 64'(i), 8'hFF);
      step();
    end
    w_en = 0; ra_en = 1; ra_addr = 5'd20; rb_en = 1; rb_addr = 5'd30;
    step();
    check("load_r20", if0.rd_data_a, 64'h01234567_00000014);
    check("load_r30", if0.rd_data_b, 64'h01234567_0000001E);
    check("load_w32_r4", 64'(if2.rd_data_a), 64'h00000000_00000014);
    check("load_d20_oor", if3.rd_data_a, 64'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_data_a", if0.rd_data_a, 64'd0);
    check("arst_data_b", if0.rd_data_b, 64'd0);
    check("arst_valid_a", 64'(if0.rd_valid_a), 64'd0);
    check("arst_valid_b", 64'(if0.rd_valid_b), 64'd0);
    check("arst_w32_data_b", 64'(if2.rd_data_b), 64'd0);
    write(5'd0, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);  // must be ignored under reset
    ra_addr = 5'd0;
    step();
    check("rst_rd_ignored", 64'(if0.rd_valid_a), 64'd0);
    reset = 1'b0; w_en = 0;

    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      step();
      check("clr_a", if0.rd_data_a, 64'd0);
      check("clr_b", if1.rd_data_b, 64'd0);
      check("clr_w32", 64'(if2.rd_data_a), 64'd0);
      check("clr_valid", 64'(if0.rd_valid_a), 64'd1);
    end

    write(5'd2, 64'h77, 8'h01);
    ra_addr = 5'd2;
    step();
    check("post_rst_write", if0.rd_data_a, 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning data width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers; legal range is 2 to 256.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register index DEPTH-1 is hardwired to zero (ARM XZR behaviour).
REQ-004 The block SHALL define local AW = $clog2(DEPTH) and local BW = WIDTH/8.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-008 The block SHALL have port wr_addr, input, AW bits, write register index.
REQ-009 The block SHALL have port wr_data, input, WIDTH bits, write data.
REQ-010 The block SHALL have port wr_be, input, BW bits, byte enables; bit k gates wr_data[8k+7:8k].
REQ-011 The block SHALL have port rd_en_a, input, 1 bit, read request on port A.
REQ-012 The block SHALL have port rd_addr_a, input, AW bits, port A read index.
REQ-013 The block SHALL have port rd_data_a, output, WIDTH bits, registered port A read data.
REQ-014 The block SHALL have port rd_valid_a, output, 1 bit, port A data valid strobe.
REQ-015 The block SHALL have ports rd_en_b, rd_addr_b, rd_data_b and rd_valid_b, identical in direction, width and meaning to port A.

Function
REQ-016 On a rising clk with wr_en=1, the block SHALL write each byte of register wr_addr whose wr_be bit is 1 and SHALL leave all other bytes unchanged.
REQ-017 With wr_en=0, or wr_be all zero, the block SHALL leave every register unchanged.
REQ-018 A write to an index >= DEPTH, or to DEPTH-1 when ZERO_REG=1, SHALL be ignored.
REQ-019 Reads SHALL have 1-cycle latency: if rd_en_x=1 at edge N, then rd_data_x and rd_valid_x=1 SHALL be presented after edge N.
REQ-020 If rd_en_x=0 at an edge, rd_valid_x SHALL be 0 after that edge, and rd_data_x SHALL hold its previous value.
REQ-021 A read of an index >= DEPTH, or of DEPTH-1 when ZERO_REG=1, SHALL return all zeros with rd_valid_x=1.
REQ-022 Same-cycle read and write to the same legal writable index SHALL be write-first: the returned data SHALL equal the old value merged with the enabled bytes of wr_data.
REQ-023 Ports A and B SHALL operate independently; both SHALL be able to read the same index in the same cycle, including the REQ-022 bypass case.
REQ-024 The block SHALL contain no combinational path from any input to rd_data_x or rd_valid_x.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for a clock edge, clear all registers, rd_data_a, rd_data_b, rd_valid_a and rd_valid_b to 0.
REQ-026 While reset=1, writes and reads SHALL be ignored.
REQ-027 On the first rising clk after reset deasserts, the block SHALL operate normally.
REQ-028 If reset is asserted mid-operation, an in-flight read SHALL produce rd_valid=0 and no write SHALL be partially committed.

Verification
REQ-029 Full-width write/read: write 0xDEADBEEF_CAFEF00D to reg 5 with wr_be=0xFF, then read on A next cycle -> rd_data_a=0xDEADBEEF_CAFEF00D, rd_valid_a=1 exactly one cycle after rd_en_a.
REQ-030 Byte enables: reg 3 holds 0x11223344_55667788; write 0xFFFFFFFF_FFFFFFFF with wr_be=0x0F -> read returns 0x11223344_FFFFFFFF.
REQ-031 Bypass: with reg 7=0, in the same cycle write 0xA5A5 (wr_be=0x03) to reg 7 while A and B both read reg 7 -> both ports return 0x000000000000A5A5.
REQ-032 Zero register: write 0x1234 to reg 31 (DEPTH=32, ZERO_REG=1) -> a read of reg 31 returns 0; with ZERO_REG=0, the same sequence returns 0x1234.
REQ-033 Hold/valid: read reg 5 once, then hold rd_en_a=0 for 3 cycles -> rd_valid_a=0 during those cycles, and rd_data_a holds 0xDEADBEEF_CAFEF00D.
REQ-034 Async reset: after loading regs 0-30, pulse reset between clock edges -> outputs go to 0 before the next edge, and subsequent reads of every index return 0; repeat with WIDTH=32, DEPTH=16.
